// File: rtl/stage_op_encode_pkg.sv
// Shared constants for the Brainfuck operation encoder: one-hot op indices,
// ASCII opcode bytes and the classification/encoding helpers.
package stage_op_encode_pkg;

    localparam int unsigned OPCODE_MSB = 7;
    localparam int unsigned OP_W       = OPCODE_MSB + 1;

    localparam int unsigned OP_RIGHT = 0;
    localparam int unsigned OP_LEFT  = 1;
    localparam int unsigned OP_INC   = 2;
    localparam int unsigned OP_DEC   = 3;
    localparam int unsigned OP_OUT   = 4;
    localparam int unsigned OP_IN    = 5;
    localparam int unsigned OP_JZ    = 6;
    localparam int unsigned OP_JNZ   = 7;

    localparam logic [7:0] OPC_RIGHT   = 8'h3E;
    localparam logic [7:0] OPC_LEFT    = 8'h3C;
    localparam logic [7:0] OPC_INC     = 8'h2B;
    localparam logic [7:0] OPC_DEC     = 8'h2D;
    localparam logic [7:0] OPC_OUT     = 8'h2E;
    localparam logic [7:0] OPC_IN      = 8'h2C;
    localparam logic [7:0] OPC_JZ      = 8'h5B;
    localparam logic [7:0] OPC_JNZ     = 8'h5D;
    localparam logic [7:0] OPC_INVALID = 8'h3F;

    typedef enum logic [1:0] {
        OpClsNop,
        OpClsSingle,
        OpClsMulti
    } op_class_e;

    function automatic op_class_e classify_op(input logic [OPCODE_MSB:0] op);
        op_class_e cls;
        if (op == '0) begin
            cls = OpClsNop;
        end else if ((op & (op - 1'b1)) == '0) begin
            cls = OpClsSingle;
        end else begin
            cls = OpClsMulti;
        end
        return cls;
    endfunction

    // Multi-hot and zero words both map to '?'; callers decide whether to push.
    function automatic logic [7:0] encode_op(input logic [OPCODE_MSB:0] op);
        logic [7:0] opc;
        opc = OPC_INVALID;
        if (classify_op(op) == OpClsSingle) begin
            if (op[OP_RIGHT]) opc = OPC_RIGHT;
            if (op[OP_LEFT])  opc = OPC_LEFT;
            if (op[OP_INC])   opc = OPC_INC;
            if (op[OP_DEC])   opc = OPC_DEC;
            if (op[OP_OUT])   opc = OPC_OUT;
            if (op[OP_IN])    opc = OPC_IN;
            if (op[OP_JZ])    opc = OPC_JZ;
            if (op[OP_JNZ])   opc = OPC_JNZ;
        end
        return opc;
    endfunction

endpackage

// File: rtl/op_byte_fifo.sv
// Synchronous byte FIFO with explicit occupancy count; full is evaluated
// before a same-cycle pop, and there is no empty bypass.
module op_byte_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned PTR_W  = 2,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [PTR_W:0]    level_o
);

    localparam logic [PTR_W:0] LevelFull = (PTR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    level_q, level_d;
    logic              do_push, do_pop;

    assign full_o  = (level_q == LevelFull);
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset; reads are masked while empty.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/stage_op_encode.sv
// Re-encodes one-hot operation words into ASCII Brainfuck opcode bytes and
// streams them out through a small FIFO over a drdy/ack byte interface.
module stage_op_encode
    import stage_op_encode_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [OPCODE_MSB:0] operation,
    input  logic              drdy_in,
    output logic              ack,
    output logic [7:0]        opcode_out,
    output logic              drdy,
    input  logic              ack_in,
    output logic [PTR_W:0]    level,
    output logic              err
);

    op_class_e  op_class;
    logic [7:0] push_byte;
    logic       accept, push, pop;
    logic       full, empty;
    logic       ack_q, ack_d;
    logic       err_q, err_d;

    always_comb begin
        op_class  = classify_op(operation);
        push_byte = encode_op(operation);
        accept    = drdy_in && !full;
        // A nop is consumed upstream but never reaches the FIFO.
        push      = accept && (op_class != OpClsNop);
        pop       = ack_in && !empty;
        ack_d     = accept;
        err_d     = err_q || (accept && (op_class == OpClsMulti));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            ack_q <= ack_d;
            err_q <= err_d;
        end
    end

    op_byte_fifo #(
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W),
        .DATA_W (8)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (push),
        .wdata_i (push_byte),
        .pop_i   (pop),
        .rdata_o (opcode_out),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level)
    );

    assign ack  = ack_q;
    assign drdy = !empty;
    assign err  = err_q;

endmodule

// File: tb/tb_stage_op_encode.sv
// Randomised and directed bench for stage_op_encode against a queue-based
// reference model of the encoder FIFO.
module tb_stage_op_encode;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned PTR_W = 2;

    logic             clk;
    logic             reset;
    logic [7:0]       operation;
    logic             drdy_in;
    logic             ack;
    logic [7:0]       opcode_out;
    logic             drdy;
    logic             ack_in;
    logic [PTR_W:0]   level;
    logic             err;

    int n_checks;
    int n_fail;
    int ack_cnt;

    logic [7:0] mq[$];
    logic       m_ack;
    logic       m_err;
    logic       m_acc;
    logic [7:0] tab [8] = '{8'h3E, 8'h3C, 8'h2B, 8'h2D, 8'h2E, 8'h2C, 8'h5B, 8'h5D};

    stage_op_encode #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .operation  (operation),
        .drdy_in    (drdy_in),
        .ack        (ack),
        .opcode_out (opcode_out),
        .drdy       (drdy),
        .ack_in     (ack_in),
        .level      (level),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        check_eq("drdy", {31'd0, drdy}, (mq.size() != 0) ? 32'd1 : 32'd0);
        check_eq("opcode_out", {24'd0, opcode_out}, (mq.size() != 0) ? {24'd0, mq[0]} : 32'd0);
        check_eq("level", {29'd0, level}, mq.size());
        check_eq("ack", {31'd0, ack}, {31'd0, m_ack});
        check_eq("err", {31'd0, err}, {31'd0, m_err});
    endtask

    // Model of one clock edge: full is judged before the pop, nop is dropped.
    task automatic model_edge(input logic dv, input logic [7:0] op, input logic ai);
        int ones;
        logic [7:0] b;
        ones  = $countones(op);
        m_acc = dv && (mq.size() != DEPTH);
        if (ai && mq.size() != 0) void'(mq.pop_front());
        if (m_acc && ones != 0) begin
            b = 8'h3F;
            if (ones == 1) begin
                for (int i = 0; i < 8; i++) if (op[i]) b = tab[i];
            end else begin
                m_err = 1'b1;
            end
            mq.push_back(b);
        end
        m_ack = m_acc;
    endtask

    task automatic tick(input logic dv, input logic [7:0] op, input logic ai);
        drdy_in   = dv;
        operation = op;
        ack_in    = ai;
        @(posedge clk);
        model_edge(dv, op, ai);
        @(negedge clk);
        compare_all();
        if (ack) ack_cnt++;
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) tick(1'b0, 8'h00, 1'b1);
    endtask

    function automatic logic [7:0] rand_op();
        int r;
        int a;
        int b;
        r = $urandom_range(0, 9);
        a = $urandom_range(0, 7);
        b = (a + $urandom_range(1, 7)) % 8;
        if (r == 0) return 8'h00;
        if (r == 1) return (8'h01 << a) | (8'h01 << b);
        return 8'h01 << a;
    endfunction

    // Reset asserted between clock edges; outputs must clear at once.
    task automatic async_reset();
        #2;
        reset = 1'b0;
        #1;
        check_eq("rst_drdy", {31'd0, drdy}, 32'd0);
        check_eq("rst_ack", {31'd0, ack}, 32'd0);
        check_eq("rst_level", {29'd0, level}, 32'd0);
        check_eq("rst_err", {31'd0, err}, 32'd0);
        check_eq("rst_opcode", {24'd0, opcode_out}, 32'd0);
        mq.delete();
        m_ack = 1'b0;
        m_err = 1'b0;
        @(negedge clk);
        compare_all();
        reset = 1'b1;
    endtask

    initial begin
        logic [7:0] ops[$];
        int idx;
        int cyc;
        n_checks  = 0;
        n_fail    = 0;
        ack_cnt   = 0;
        m_ack     = 1'b0;
        m_err     = 1'b0;
        m_acc     = 1'b0;
        reset     = 1'b0;
        drdy_in   = 1'b0;
        operation = 8'h00;
        ack_in    = 1'b0;
        repeat (3) @(negedge clk);
        compare_all();
        reset = 1'b1;

        // All eight ops in bit order with the sink always ready.
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 8'h01 << i, 1'b1);
            if (i == 0) begin
                check_eq("first_drdy", {31'd0, drdy}, 32'd1);
                check_eq("first_byte", {24'd0, opcode_out}, 32'h3E);
            end
        end
        drain();
        check_eq("no_err_single", {31'd0, err}, 32'd0);

        // Nop between two valid ops: three acks, two bytes.
        ack_cnt = 0;
        tick(1'b1, 8'h04, 1'b0);
        tick(1'b1, 8'h00, 1'b0);
        tick(1'b1, 8'h08, 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        check_eq("nop_level", {29'd0, level}, 32'd2);
        check_eq("nop_acks", ack_cnt, 32'd3);
        drain();

        // Backpressure: six ops, sink stalled, upstream holds unaccepted op.
        ops = '{8'h01, 8'h02, 8'h10, 8'h20, 8'h40, 8'h80};
        idx = 0;
        cyc = 0;
        while (idx < ops.size() && cyc < 64) begin
            tick(1'b1, ops[idx], cyc >= 6);
            if (cyc == 5) begin
                check_eq("bp_full", {29'd0, level}, 32'd4);
                check_eq("bp_noack", {31'd0, ack}, 32'd0);
            end
            if (m_acc) idx++;
            cyc++;
        end
        check_eq("bp_done", idx, ops.size());
        drain();

        // Push and pop together while full.
        for (int i = 0; i < 4; i++) tick(1'b1, 8'h01 << i, 1'b0);
        tick(1'b1, 8'h40, 1'b1);
        check_eq("fullpop_level", {29'd0, level}, 32'd3);
        check_eq("fullpop_ack", {31'd0, ack}, 32'd0);
        tick(1'b1, 8'h40, 1'b0);
        check_eq("fullpop_retry", {29'd0, level}, 32'd4);
        drain();

        // Multi-hot word: '?' byte and a sticky err.
        tick(1'b1, 8'h05, 1'b1);
        check_eq("multi_byte", {24'd0, opcode_out}, 32'h3F);
        for (int i = 0; i < 10; i++) tick(1'b1, 8'h01 << $urandom_range(0, 7), 1'b1);
        check_eq("err_sticky", {31'd0, err}, 32'd1);
        drain();

        // Async reset mid-stream with three bytes queued.
        for (int i = 0; i < 3; i++) tick(1'b1, 8'h04, 1'b0);
        check_eq("pre_rst_level", {29'd0, level}, 32'd3);
        async_reset();
        tick(1'b1, 8'h80, 1'b1);
        check_eq("post_rst_byte", {24'd0, opcode_out}, 32'h5D);
        drain();

        // Random traffic with one mid-run reset.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) async_reset();
            tick($urandom_range(0, 3) != 0, rand_op(), $urandom_range(0, 2) != 0);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
